// File: rtl/seg7_pkg.sv
// Shared constants for the clock display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [1:0] dig_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  // Index n holds the pattern for BCD digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam dig_t DIG_SU = 2'd0;
  localparam dig_t DIG_ST = 2'd1;
  localparam dig_t DIG_MU = 2'd2;
  localparam dig_t DIG_MT = 2'd3;

endpackage

// File: rtl/seg7_clock_scanner_if.sv
// Display bundle: clock word and flags in, anode/segment/dp out.
// master drives bcd_in/turn/times_up, slave drives an/seg/dp.
interface seg7_clock_scanner_if;

  logic [15:0] bcd_in;
  logic        turn;
  logic        times_up;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output bcd_in, turn, times_up,
    input  an, seg, dp
  );

  modport slave (
    input  bcd_in, turn, times_up,
    output an, seg, dp
  );

endinterface

// File: rtl/seg7_clock_scanner_bcd_to_seg7.sv
// Nibble to seven-segment decoder, combinational.
// Ports: nib (BCD nibble) in, seg ({g..a}, active-low) out.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Non-BCD codes show a dash so corrupt input is visible.
  always_comb begin
    seg = SEG_DASH;
    if (nib <= 4'd9)
      seg = SEG_DIGITS[nib];
  end

endmodule

// File: rtl/seg7_clock_scanner.sv
// Scans an MM:SS BCD word onto a 4-digit common-anode display.
// Ports: clk, rst (async, active-high), bus (slave: bcd_in/turn/times_up in, an/seg/dp out).
module seg7_clock_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2000,
  parameter int BLINK_DIV = 25000000
) (
  input logic                 clk,
  input logic                 rst,
  seg7_clock_scanner_if.slave bus
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  dig_t          dig_idx;
  logic [15:0]   snap;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic          scan_wrap;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic          hide;

  assign scan_wrap = (scan_cnt == SCAN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= DIG_SU;
      snap     <= 16'h0000;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) begin
        dig_idx <= dig_idx + 2'd1;
        // Latch a whole frame at once so digits never tear.
        if (dig_idx == DIG_MT)
          snap <= bus.bcd_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!bus.times_up) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    nib = 4'h0;
    unique case (dig_idx)
      DIG_SU: nib = snap[3:0];
      DIG_ST: nib = snap[7:4];
      DIG_MU: nib = snap[11:8];
      DIG_MT: nib = snap[15:12];
    endcase
  end

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_comb begin
    seg_n = dec_seg;
    if (dig_idx == DIG_MT && snap[15:12] == 4'h0)
      seg_n = SEG_BLANK;

    dp_n = 1'b1;
    unique case (dig_idx)
      DIG_SU: dp_n = ~bus.turn;
      DIG_ST: dp_n = 1'b1;
      DIG_MU: dp_n = 1'b0;
      DIG_MT: dp_n = 1'b1;
    endcase

    // Gating on times_up lets scanning resume as soon as it drops.
    hide = (scan_cnt < BLANK_END) ||
           (bus.times_up && !blink_on);
    an_n = hide ? AN_OFF : ~(4'b0001 << dig_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an  <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_n;
      bus.seg <= seg_n;
      bus.dp  <= dp_n;
    end
  end

endmodule
